// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The optional output skid buffer is enabled by defining RR_MUX_ARBITER_SKID_EN.
package rr_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    // Index width that never collapses to zero bits.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating find-first-set: first asserted req at or after ptr+1, wrapping to 0.
module rr_priority_pick #(
    parameter int N = 32,
    parameter int W = 5
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] start;
    logic [N-1:0] upper_mask;
    logic [N-1:0] req_upper;

    assign start = (int'(ptr) >= N - 1) ? '0 : ptr + 1'b1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign upper_mask[gi] = (int'(start) <= gi);
        end
    endgenerate

    assign req_upper = req & upper_mask;

    // Lowest requester at/after start wins; otherwise the search wraps to the lowest overall.
    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = W'(i);
        end
        if (|req_upper) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (req_upper[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-to-1 registered mux with fixed-select and round-robin modes.
// Define RR_MUX_ARBITER_SKID_EN for a 2-entry output skid buffer.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int NUM_CH = 32,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         grant_idx
);

    mux_mode_e           mode_e;
    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic [SEL_W-1:0]    grant_next;
    logic                granted;
    logic                load_en;
    logic                transfer;
    logic [DATA_W-1:0]   data_next;
    logic [SEL_W-1:0]    rr_ptr_reg;
    logic                out_valid_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic [SEL_W-1:0]    grant_idx_reg;

    assign mode_e = mux_mode_e'(mode);

    rr_priority_pick #(
        .N (NUM_CH),
        .W (SEL_W)
    ) u_pick (
        .req   (in_valid),
        .ptr   (rr_ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        grant_next = sel;
        granted    = 1'b0;
        if (mode_e == MODE_RR) begin
            grant_next = pick_idx;
            granted    = pick_found;
        end else if (int'(sel) < NUM_CH) begin
            granted = in_valid[sel];
        end
    end

    assign transfer  = load_en && granted;
    assign data_next = in_data[int'(grant_next)*DATA_W +: DATA_W];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign in_ready[gi] = transfer && (int'(grant_next) == gi);
        end
    endgenerate

    // Pointer only advances on an accepted round-robin word; fixed mode leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= SEL_W'(NUM_CH - 1);
        end else if (transfer && mode_e == MODE_RR) begin
            rr_ptr_reg <= grant_next;
        end
    end

`ifdef RR_MUX_ARBITER_SKID_EN
    logic              skid_valid_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic [SEL_W-1:0]  skid_idx_reg;
    logic              out_free;

    // Acceptance depends only on registered state, cutting the out_ready -> in_ready path.
    assign load_en  = rst_n && !skid_valid_reg;
    assign out_free = !out_valid_reg || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            grant_idx_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_idx_reg   <= '0;
        end else if (skid_valid_reg) begin
            if (out_ready) begin
                out_data_reg   <= skid_data_reg;
                grant_idx_reg  <= skid_idx_reg;
                skid_valid_reg <= 1'b0;
            end
        end else if (transfer) begin
            if (out_free) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= data_next;
                grant_idx_reg <= grant_next;
            end else begin
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= data_next;
                skid_idx_reg   <= grant_next;
            end
        end else if (out_free) begin
            out_valid_reg <= 1'b0;
        end
    end
`else
    assign load_en = rst_n && (!out_valid_reg || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            grant_idx_reg <= '0;
        end else if (transfer) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= data_next;
            grant_idx_reg <= grant_next;
        end else if (load_en) begin
            out_valid_reg <= 1'b0;
        end
    end
`endif

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign grant_idx = grant_idx_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomised self-checking bench for rr_mux_arbiter against a queue-based reference model.
module tb_rr_mux_arbiter;

    localparam int N = 32;
`ifdef RR_MUX_ARBITER_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic [N*8-1:0]   in_data;
    logic [N-1:0]     in_valid;
    logic [N-1:0]     in_ready;
    logic             mode;
    logic [4:0]       sel;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       grant_idx;

    logic [33*8-1:0]  in_data33;
    logic [32:0]      in_valid33;
    logic [32:0]      in_ready33;
    logic             mode33;
    logic [5:0]       sel33;
    logic [7:0]       out_data33;
    logic             out_valid33;
    logic             out_ready33;
    logic [5:0]       grant_idx33;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter #(.NUM_CH(N), .DATA_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .grant_idx(grant_idx)
    );

    rr_mux_arbiter #(.NUM_CH(33), .DATA_W(8)) u_dut33 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data33), .in_valid(in_valid33),
        .in_ready(in_ready33), .mode(mode33), .sel(sel33), .out_data(out_data33),
        .out_valid(out_valid33), .out_ready(out_ready33), .grant_idx(grant_idx33)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: FIFO of words owned by the output stage, head is what the consumer sees.
    typedef struct {
        logic [7:0] data;
        int         idx;
    } word_t;

    word_t      mq[$];
    int         m_ptr;
    logic [7:0] last_data;
    int         last_idx;
    logic [N-1:0] exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_idx;
    bit         exp_xfer;
    int         exp_cand;

    task automatic model_reset();
        mq.delete();
        m_ptr     = N - 1;
        last_data = 8'h00;
        last_idx  = 0;
    endtask

    task automatic model_eval();
        bit free_slot;
        bit g;
        int c;
        int j;
        free_slot = SKID ? (mq.size() < 2) : (mq.size() == 0 || out_ready);
        g = 1'b0;
        c = 0;
        if (mode == 1'b0) begin
            c = int'(sel);
            g = (c < N) && in_valid[c];
        end else begin
            for (int k = 1; k <= N; k++) begin
                j = (m_ptr + k) % N;
                if (!g && in_valid[j]) begin
                    g = 1'b1;
                    c = j;
                end
            end
        end
        exp_xfer  = free_slot && g && rst_n;
        exp_cand  = c;
        exp_ready = '0;
        if (exp_xfer) exp_ready[c] = 1'b1;
        exp_valid = (mq.size() > 0);
        exp_data  = exp_valid ? mq[0].data : last_data;
        exp_idx   = 5'(exp_valid ? mq[0].idx : last_idx);
    endtask

    task automatic model_commit();
        word_t w;
        if (out_ready && mq.size() > 0) void'(mq.pop_front());
        if (exp_xfer) begin
            w.data    = in_data[exp_cand*8 +: 8];
            w.idx     = exp_cand;
            last_data = w.data;
            last_idx  = w.idx;
            mq.push_back(w);
            if (mode == 1'b1) m_ptr = exp_cand;
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[i*8 +: 8] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = '1;
        mode = 1'b1;
        sel = 5'd0;
        out_ready = 1'b1;
        rand_data();
        model_reset();
        @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0 || in_ready !== '0 || out_data !== 8'h00 || grant_idx !== 5'd0) begin
                bad++;
                $display("FAIL reset_state cyc=%0d got v=%b rdy=%h d=%h g=%0d want v=0 rdy=0 d=00 g=0",
                         n, out_valid, in_ready, out_data, grant_idx);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        model_eval();
        total++;
        if (in_ready !== 32'h1) begin
            bad++;
            $display("FAIL reset_first_grant got=%h want=00000001", in_ready);
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_rr_fair();
        in_valid = '1;
        mode = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 34; n++) begin
            rand_data();
            @(negedge clk);
            model_eval();
            total++;
            if (in_ready !== exp_ready || out_valid !== exp_valid || out_data !== exp_data || grant_idx !== exp_idx) begin
                bad++;
                $display("FAIL rr_fair cyc=%0d got rdy=%h v=%b d=%h g=%0d want rdy=%h v=%b d=%h g=%0d",
                         n, in_ready, out_valid, out_data, grant_idx, exp_ready, exp_valid, exp_data, exp_idx);
            end
            @(posedge clk);
            model_commit();
            #1;
        end
    endtask

    task automatic test_rr_skip_wrap();
        int want;
        mode = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 9; n++) begin
            rand_data();
            if (n == 0) in_valid = 32'h1 << 30;
            else if (n < 5) in_valid = (32'h1 << 30) | (32'h1 << 3);
            else in_valid = 32'h1 << 5;
            want = (n == 0) ? 30 : (n < 5) ? ((n % 2 == 1) ? 3 : 30) : 5;
            @(negedge clk);
            model_eval();
            total++;
            if (in_ready !== (32'h1 << want) || in_ready !== exp_ready) begin
                bad++;
                $display("FAIL rr_skip_wrap cyc=%0d got rdy=%h want ch=%0d", n, in_ready, want);
            end
            total++;
            if (out_valid !== exp_valid || out_data !== exp_data || grant_idx !== exp_idx) begin
                bad++;
                $display("FAIL rr_skip_wrap_out cyc=%0d got v=%b d=%h g=%0d want v=%b d=%h g=%0d",
                         n, out_valid, out_data, grant_idx, exp_valid, exp_data, exp_idx);
            end
            @(posedge clk);
            model_commit();
            #1;
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0;
        sel = 5'd7;
        out_ready = 1'b1;
        rand_data();
        in_data[7*8 +: 8] = 8'hA5;
        in_valid = 32'($urandom) | (32'h1 << 7);
        @(negedge clk);
        model_eval();
        total++;
        if (in_ready !== (32'h1 << 7)) begin
            bad++;
            $display("FAIL fixed_ready got=%h want=00000080", in_ready);
        end
        @(posedge clk);
        model_commit();
        #1;
        sel = 5'd12;
        in_valid = '0;
        @(negedge clk);
        model_eval();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || grant_idx !== 5'd7) begin
            bad++;
            $display("FAIL fixed_out got v=%b d=%h g=%0d want v=1 d=a5 g=7", out_valid, out_data, grant_idx);
        end
        total++;
        if (in_ready !== '0) begin
            bad++;
            $display("FAIL fixed_invalid_sel got=%h want=00000000", in_ready);
        end
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_backpressure();
        int stall_acc;
        stall_acc = 0;
        mode = 1'b1;
        in_valid = '1;
        for (int n = 0; n < 10; n++) begin
            rand_data();
            out_ready = (n >= 3 && n < 7) ? 1'b0 : 1'b1;
            @(negedge clk);
            model_eval();
            if (n >= 3 && n < 7 && |in_ready) stall_acc++;
            total++;
            if (in_ready !== exp_ready || out_valid !== exp_valid || out_data !== exp_data || grant_idx !== exp_idx) begin
                bad++;
                $display("FAIL backpressure cyc=%0d got rdy=%h v=%b d=%h g=%0d want rdy=%h v=%b d=%h g=%0d",
                         n, in_ready, out_valid, out_data, grant_idx, exp_ready, exp_valid, exp_data, exp_idx);
            end
            @(posedge clk);
            model_commit();
            #1;
        end
        total++;
        if (stall_acc !== (SKID ? 1 : 0)) begin
            bad++;
            $display("FAIL backpressure_accepts got=%0d want=%0d", stall_acc, SKID ? 1 : 0);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rand_data();
            in_valid  = ($urandom_range(0, 3) == 0) ? 32'($urandom) & 32'($urandom) : 32'($urandom);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = 5'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            model_eval();
            total++;
            if (in_ready !== exp_ready || out_valid !== exp_valid || out_data !== exp_data || grant_idx !== exp_idx) begin
                bad++;
                $display("FAIL random cyc=%0d got rdy=%h v=%b d=%h g=%0d want rdy=%h v=%b d=%h g=%0d",
                         n, in_ready, out_valid, out_data, grant_idx, exp_ready, exp_valid, exp_data, exp_idx);
            end
            @(posedge clk);
            model_commit();
            #1;
        end
    endtask

    task automatic test_async_reset();
        mode = 1'b1;
        in_valid = '1;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            rand_data();
            @(posedge clk);
            model_eval();
            model_commit();
            #1;
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== '0) begin
            bad++;
            $display("FAIL async_reset_drop got v=%b rdy=%h want v=0 rdy=0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            rand_data();
            @(negedge clk);
            model_eval();
            total++;
            if (in_ready !== (32'h1 << n) || in_ready !== exp_ready || out_valid !== exp_valid || out_data !== exp_data) begin
                bad++;
                $display("FAIL async_reset_restart cyc=%0d got rdy=%h v=%b d=%h want rdy=%h v=%b d=%h",
                         n, in_ready, out_valid, out_data, exp_ready, exp_valid, exp_data);
            end
            @(posedge clk);
            model_commit();
            #1;
        end
    endtask

    task automatic test_fixed_out_of_range();
        mode33 = 1'b0;
        sel33 = 6'd40;
        in_valid33 = '1;
        out_ready33 = 1'b1;
        for (int i = 0; i < 33; i++) in_data33[i*8 +: 8] = 8'($urandom);
        in_data33[32*8 +: 8] = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (in_ready33 !== '0 || out_valid33 !== 1'b0) begin
            bad++;
            $display("FAIL fixed_oob got rdy=%h v=%b want rdy=0 v=0", in_ready33, out_valid33);
        end
        @(posedge clk);
        #1;
        sel33 = 6'd32;
        @(negedge clk);
        total++;
        if (in_ready33 !== (33'h1 << 32)) begin
            bad++;
            $display("FAIL fixed_last_ch_ready got=%h want=100000000", in_ready33);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (out_valid33 !== 1'b1 || out_data33 !== 8'h3C || grant_idx33 !== 6'd32) begin
            bad++;
            $display("FAIL fixed_last_ch_out got v=%b d=%h g=%0d want v=1 d=3c g=32",
                     out_valid33, out_data33, grant_idx33);
        end
    endtask

    initial begin
        mode33 = 1'b0;
        sel33 = 6'd40;
        in_valid33 = '0;
        in_data33 = '0;
        out_ready33 = 1'b1;
        in_data = '0;
        test_reset();
        test_rr_fair();
        test_rr_skip_wrap();
        test_fixed();
        test_backpressure();
        test_random();
        test_async_reset();
        test_fixed_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
